// File: rtl/heartbeat_if.sv
// Emotion/sleep inputs and heartbeat level exchanged between the creature core and the heartbeat model.
interface heartbeat_if;
  logic [7:0] emotion;
  logic       asleep;
  logic [1:0] heartbeat;

  modport master (output emotion, output asleep, input heartbeat);
  modport slave  (input emotion, input asleep, output heartbeat);
endinterface

// File: rtl/heartbeat_model.sv
// Slew-limited heartbeat level: moves one level toward the emotion/sleep target
// after STEP_CYCLES consecutive mismatching clocks.
module heartbeat_model #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst,
  heartbeat_if.slave hb
);

  localparam int unsigned    CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    LVL_REST     = 2'd0,
    LVL_NORMAL   = 2'd1,
    LVL_ELEVATED = 2'd2,
    LVL_RACING   = 2'd3
  } level_e;

  level_e             target;
  level_e             level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Calm/happy/content/bored all map to the normal level, so their bits are never decoded.
  logic unused_calm_flags;
  assign unused_calm_flags = ^hb.emotion[3:0];

  always_comb begin
    target = LVL_NORMAL;
    if (hb.asleep)                          target = LVL_REST;
    else if (hb.emotion[7] || hb.emotion[6]) target = LVL_RACING;
    else if (hb.emotion[5] || hb.emotion[4]) target = LVL_ELEVATED;
  end

  // The count survives target changes while the mismatch persists; only a match or a step clears it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (level_q == target) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = (target > level_q) ? level_e'(level_q + 2'd1) : level_e'(level_q - 2'd1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= LVL_NORMAL;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hb.heartbeat = level_q;

endmodule

// File: tb/tb_heartbeat_model.sv
// Bench for heartbeat_model: directed scenarios plus randomized traffic against a rule-level model,
// for STEP_CYCLES=4 and STEP_CYCLES=1 builds.
module tb_heartbeat_model;

  logic clk = 1'b0;
  logic rst4, rst1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  heartbeat_if if4 ();
  heartbeat_if if1 ();

  heartbeat_model #(.STEP_CYCLES(4)) dut4 (.clk(clk), .rst(rst4), .hb(if4.slave));
  heartbeat_model #(.STEP_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .hb(if1.slave));

  // Reference: level from the priority rules; a step happens once the mismatch has lasted N edges.
  function automatic int target_of(input logic [7:0] emo, input logic slp);
    if (slp) return 0;
    if (emo[7:6] != 2'b00) return 3;
    if (emo[5:4] != 2'b00) return 2;
    return 1;
  endfunction

  int m4_hb, m4_run, m1_hb, m1_run;

  always @(posedge clk) begin
    int t;
    if (rst4) begin
      m4_hb = 1; m4_run = 0;
    end else begin
      t = target_of(if4.emotion, if4.asleep);
      if (t == m4_hb) m4_run = 0;
      else begin
        m4_run++;
        if (m4_run == 4) begin
          m4_hb  = m4_hb + ((t > m4_hb) ? 1 : -1);
          m4_run = 0;
        end
      end
    end
    if (rst1) begin
      m1_hb = 1; m1_run = 0;
    end else begin
      t = target_of(if1.emotion, if1.asleep);
      if (t != m1_hb) m1_hb = m1_hb + ((t > m1_hb) ? 1 : -1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst1 = 1'b1;
    if4.emotion = 8'hFF; if4.asleep = 1'b1;
    if1.emotion = 8'hFF; if1.asleep = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (if4.heartbeat !== 2'd1) begin
        errors++; $display("FAIL reset4 edge%0d: got %0d expected 1", i, if4.heartbeat);
      end
      checks++;
      if (if1.heartbeat !== 2'd1) begin
        errors++; $display("FAIL reset1 edge%0d: got %0d expected 1", i, if1.heartbeat);
      end
    end
    if4.emotion = 8'h00; if4.asleep = 1'b0;
    if1.emotion = 8'h00; if1.asleep = 1'b0;
  endtask

  task automatic test_ramp_up();
    int exp_seq[12] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3};
    rst4 = 1'b0; rst1 = 1'b0;
    if4.emotion = 8'h80; if4.asleep = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (if4.heartbeat !== 2'(exp_seq[i])) begin
        errors++; $display("FAIL ramp edge%0d: got %0d expected %0d", i + 1, if4.heartbeat, exp_seq[i]);
      end
    end
  endtask

  task automatic test_sleep_override();
    int exp_seq[16] = '{3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    if4.asleep = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (if4.heartbeat !== 2'(exp_seq[i])) begin
        errors++; $display("FAIL sleep edge%0d: got %0d expected %0d", i + 1, if4.heartbeat, exp_seq[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] emos[4] = '{8'h30, 8'h41, 8'h0F, 8'h00};
    int         lvls[4] = '{2, 3, 1, 1};
    if4.asleep = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if4.emotion = emos[k];
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (if4.heartbeat !== 2'(lvls[k])) begin
        errors++; $display("FAIL priority emo=%h: got %0d expected %0d", emos[k], if4.heartbeat, lvls[k]);
      end
      checks++;
      if (if4.heartbeat !== 2'(m4_hb)) begin
        errors++; $display("FAIL priority_model emo=%h: got %0d expected %0d", emos[k], if4.heartbeat, m4_hb);
      end
    end
  endtask

  task automatic test_aborted_step();
    // Three mismatching edges, one matching edge, then a fresh mismatch must need the full four.
    int exp_seq[8] = '{1, 1, 1, 1, 1, 1, 1, 2};
    for (int i = 0; i < 8; i++) begin
      if4.emotion = (i == 3) ? 8'h01 : 8'h10;
      tick();
      checks++;
      if (if4.heartbeat !== 2'(exp_seq[i])) begin
        errors++; $display("FAIL aborted edge%0d: got %0d expected %0d", i + 1, if4.heartbeat, exp_seq[i]);
      end
    end
    if4.emotion = 8'h00;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset_mid_count();
    int exp_seq[8] = '{1, 1, 1, 1, 1, 1, 1, 2};
    if4.emotion = 8'h80;
    for (int i = 0; i < 8; i++) begin
      rst4 = (i == 3);
      tick();
      checks++;
      if (if4.heartbeat !== 2'(exp_seq[i])) begin
        errors++; $display("FAIL rst_mid edge%0d: got %0d expected %0d", i + 1, if4.heartbeat, exp_seq[i]);
      end
    end
    rst4 = 1'b0;
  endtask

  task automatic test_step1();
    int exp_seq[4] = '{2, 3, 1, 2};
    if1.emotion = 8'h80; if1.asleep = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rst1 = (i == 2);
      tick();
      checks++;
      if (if1.heartbeat !== 2'(exp_seq[i])) begin
        errors++; $display("FAIL step1 edge%0d: got %0d expected %0d", i + 1, if1.heartbeat, exp_seq[i]);
      end
    end
    rst1 = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] pool[6] = '{8'h00, 8'h0F, 8'h10, 8'h20, 8'h40, 8'h80};
    int hold4 = 0, hold1 = 0;
    int prev4, prev1;
    prev4 = int'(if4.heartbeat);
    prev1 = int'(if1.heartbeat);
    for (int i = 0; i < 800; i++) begin
      if (hold4 == 0) begin
        if4.emotion = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)];
        if4.asleep  = ($urandom_range(0, 5) == 0);
        hold4 = $urandom_range(1, 12);
      end
      if (hold1 == 0) begin
        if1.emotion = 8'($urandom);
        if1.asleep  = ($urandom_range(0, 4) == 0);
        hold1 = $urandom_range(1, 4);
      end
      rst4 = ($urandom_range(0, 199) == 0);
      rst1 = ($urandom_range(0, 199) == 0);
      hold4--; hold1--;
      tick();
      checks++;
      if (if4.heartbeat !== 2'(m4_hb)) begin
        errors++; $display("FAIL rand4 cyc%0d: got %0d expected %0d", i, if4.heartbeat, m4_hb);
      end
      checks++;
      if (if1.heartbeat !== 2'(m1_hb)) begin
        errors++; $display("FAIL rand1 cyc%0d: got %0d expected %0d", i, if1.heartbeat, m1_hb);
      end
      checks++;
      if (int'(if4.heartbeat) - prev4 > 1 || prev4 - int'(if4.heartbeat) > 1) begin
        errors++; $display("FAIL slew4 cyc%0d: got %0d from %0d", i, if4.heartbeat, prev4);
      end
      prev4 = int'(if4.heartbeat);
      prev1 = int'(if1.heartbeat);
    end
    rst4 = 1'b0; rst1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_sleep_override();
    test_priority();
    test_aborted_step();
    test_reset_mid_count();
    test_step1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
